wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback arbiter/hazard stage feeding the writeback mux stage; sits between the scalar/vector pipeline final stages and that stage.
- Decides each cycle which pipeline owns the scalar register file and the vector register file. Drives the mux selects and the one-entry vector-result buffer controls.
- Tracks buffered destination addresses and drives the register-file write addresses.
- Vector pipeline never stalls. The scalar pipeline is stalled when a buffer would otherwise overflow.

Parameters:
- REG_ADDR_W, 5, scalar register file address width
- VREG_ADDR_W, 5, vector register file address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- scalar_rreq  in  1  scalar pipeline writes register file this cycle
- scalar_vreq  in  1  scalar pipeline writes vector register file this cycle
- vector_rreq  in  1  vector pipeline writes register file this cycle
- vector_vreq  in  1  vector pipeline writes vector register file this cycle
- scalar_raddr / vector_raddr  in  REG_ADDR_W  destination registers
- scalar_vaddr / vector_vaddr  in  VREG_ADDR_W  destination vector registers
- register_wb_sel, buffer_register_sel, buffer_register  out  1  register-file mux select / buffered select / buffer load
- vector_wb_sel, buffer_vector_sel, buffer_vector  out  1  same three controls, vector file
- register_waddr  out  REG_ADDR_W  register-file write address
- vector_waddr  out  VREG_ADDR_W  vector-file write address
- stall_scalar  out  1  scalar pipeline holds its writeback next cycle
- scalar_wb_kill  out  1  gates scalar write enables this cycle (equals stall_scalar)
- pend_reg_valid  out  1  register-file buffer holds a result
- pend_reg_addr  out  REG_ADDR_W  its destination
- pend_vreg_valid  out  1  vector-file buffer holds a result
- pend_vreg_addr  out  VREG_ADDR_W  its destination

Behaviour:
- Two independent lanes (register, vector), identical. Each lane has state BUF_EMPTY/BUF_FULL plus a buffered address register. Below, s = scalar request and v = vector request for that lane.
- BUF_EMPTY:
  - !s & !v: sel=0, bsel=0, load=0.
  - !s & v: sel=1, bsel=0, load=0; the vector result writes directly.
  - s & !v: sel=0.
  - s & v: sel=0 (scalar wins), load=1, capture vector addr, next BUF_FULL.
- BUF_FULL (drain has priority, prevents starvation):
  - Always sel=1, bsel=1; the buffered result writes.
  - v: load=1, capture new addr, stay BUF_FULL. The flop captures the new result while the old one is output.
  - !v: next BUF_EMPTY.
  - s: lane stall request=1.
- stall_scalar = OR of both lanes' stall requests, combinational, same cycle.
  - scalar_wb_kill = stall_scalar. Suppresses the scalar write in both files, so the replay next cycle cannot reorder against vector writes.
  - A lane whose own scalar request is killed still reports sel=0 when EMPTY; the kill gates the enable.
- Write address:
  - register_waddr = bsel ? buffered addr : (sel ? vector_raddr : scalar_raddr). vector_waddr is analogous.
- Pending outputs:
  - pend_*_valid = (state==BUF_FULL); pend_*_addr = buffered addr. These are consumed by decode hazard logic.
- Latency: direct paths are combinational, zero cycles. A buffered vector result writes exactly 1 cycle after capture. Back-to-back conflicts keep each result at 1 cycle of delay.
- Reset (rst==0 at posedge):
  - State BUF_EMPTY, buffered addrs 0.
  - All outputs 0: sel/bsel/load follow state with no requests; stall 0.
  - A buffered result present at mid-operation reset is discarded.
- Requests are sampled every cycle regardless of stall; the scalar pipeline re-presents its stalled request.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- Defined: adds outputs conflict_cnt and stall_cnt (16 bits each).
  - conflict_cnt increments on each lane EMPTY→FULL transition; +2 if both lanes transition in one cycle.
  - stall_cnt increments on each stall_scalar cycle.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package wb_pkg:
  - typedef enum logic {BUF_EMPTY, BUF_FULL} wb_buf_state_e
  - REG_ADDR_W/VREG_ADDR_W defaults
  - counter width constant
- Sub-module wb_arb_lane:
  - Parameterised by address width.
  - Holds FSM, buffered addr, sel/bsel/load/addr/stall-request outputs.
  - Instantiated twice.

Test Plan:
- Reset: hold rst=0 two cycles with all requests 1 → all outputs 0, pend_*_valid=0. Release → normal arbitration.
- Register-file conflict: scalar_rreq=1 (addr 3) with vector_rreq=1 (addr 7).
  - Cycle 0: register_wb_sel=0, buffer_register=1, register_waddr=3.
  - Cycle 1 (no reqs): register_wb_sel=1, buffer_register_sel=1, register_waddr=7; then EMPTY.
- Overflow: after a conflict, drive scalar_rreq=1 (addr 4) and vector_rreq=1 (addr 9) → stall_scalar=1, scalar_wb_kill=1, waddr=7, buffer_register=1.
  - Next cycle: scalar re-presents, stall again while 9 drains; then scalar 4 writes.
- Lane independence: vector-file conflict (vaddrs 2/5) alongside a vector-only register write (raddr 6) → vector lane buffers 5; register lane writes 6 direct, no stall.
- Mid-operation reset: buffer FULL with addr 12, rst=0 one cycle → pend_vreg_valid=0 and no buffered write afterwards.
- Stats (WB_ARB_STATS_EN): 3 conflicts and 2 stalls → conflict_cnt=3, stall_cnt=2. Preload a near-max count and confirm saturation at 16'hFFFF.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter and its per-file lanes.
// The optional statistics counters are enabled by defining WB_ARB_STATS_EN.
package wb_pkg;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } wb_buf_state_e;

    localparam int REG_ADDR_W_DEF  = 5;
    localparam int VREG_ADDR_W_DEF = 5;
    localparam int STAT_CNT_W      = 16;

    // Saturating increment used by the statistics counters.
    function automatic logic [STAT_CNT_W-1:0] sat_add(
        input logic [STAT_CNT_W-1:0] cnt,
        input logic [1:0]            inc
    );
        logic [STAT_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(STAT_CNT_W-1){1'b0}}, inc};
        if (sum[STAT_CNT_W]) begin
            sat_add = {STAT_CNT_W{1'b1}};
        end else begin
            sat_add = sum[STAT_CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/wb_arb_lane.sv
// One register-file lane of the writeback arbiter: a one-entry buffer that
// parks the vector result whenever the scalar pipeline wins the write port.
module wb_arb_lane
    import wb_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_req,
    input  logic              v_req,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [ADDR_W-1:0] v_addr,
    output logic              sel,
    output logic              bsel,
    output logic              load,
    output logic [ADDR_W-1:0] waddr,
    output logic              stall_req,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr
);

    wb_buf_state_e     state_r;
    wb_buf_state_e     state_nxt_s;
    logic [ADDR_W-1:0] buf_addr_r;
    logic [ADDR_W-1:0] buf_addr_nxt_s;
    logic              sel_s;
    logic              bsel_s;
    logic              load_s;
    logic              stall_s;

    // Arbitration: a parked result always drains first so it cannot starve.
    always_comb begin
        state_nxt_s    = state_r;
        buf_addr_nxt_s = buf_addr_r;
        sel_s          = 1'b0;
        bsel_s         = 1'b0;
        load_s         = 1'b0;
        stall_s        = 1'b0;
        case (state_r)
            BUF_EMPTY: begin
                if (v_req && s_req) begin
                    load_s         = 1'b1;
                    buf_addr_nxt_s = v_addr;
                    state_nxt_s    = BUF_FULL;
                end else if (v_req) begin
                    sel_s = 1'b1;
                end else begin
                    sel_s = 1'b0;
                end
            end
            BUF_FULL: begin
                sel_s   = 1'b1;
                bsel_s  = 1'b1;
                stall_s = s_req;
                if (v_req) begin
                    load_s         = 1'b1;
                    buf_addr_nxt_s = v_addr;
                end else begin
                    state_nxt_s = BUF_EMPTY;
                end
            end
            default: begin
                state_nxt_s = BUF_EMPTY;
            end
        endcase
    end

    // Buffer state and parked destination; reset discards any parked result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= BUF_EMPTY;
            buf_addr_r <= {ADDR_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            buf_addr_r <= buf_addr_nxt_s;
        end
    end

    // Outputs are forced quiet while reset is asserted, whatever the requests.
    assign sel        = rst & sel_s;
    assign bsel       = rst & bsel_s;
    assign load       = rst & load_s;
    assign stall_req  = rst & stall_s;
    assign pend_valid = rst & (state_r == BUF_FULL);
    assign pend_addr  = rst ? buf_addr_r : {ADDR_W{1'b0}};
    assign waddr      = !rst  ? {ADDR_W{1'b0}} :
                        bsel_s ? buf_addr_r :
                        sel_s  ? v_addr : s_addr;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: register-file and vector-file lanes plus scalar stall.
// Define WB_ARB_STATS_EN to add saturating conflict_cnt/stall_cnt outputs.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int VREG_ADDR_W = VREG_ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scalar_rreq,
    input  logic                   scalar_vreq,
    input  logic                   vector_rreq,
    input  logic                   vector_vreq,
    input  logic [REG_ADDR_W-1:0]  scalar_raddr,
    input  logic [REG_ADDR_W-1:0]  vector_raddr,
    input  logic [VREG_ADDR_W-1:0] scalar_vaddr,
    input  logic [VREG_ADDR_W-1:0] vector_vaddr,
    output logic                   register_wb_sel,
    output logic                   buffer_register_sel,
    output logic                   buffer_register,
    output logic                   vector_wb_sel,
    output logic                   buffer_vector_sel,
    output logic                   buffer_vector,
    output logic [REG_ADDR_W-1:0]  register_waddr,
    output logic [VREG_ADDR_W-1:0] vector_waddr,
    output logic                   stall_scalar,
    output logic                   scalar_wb_kill,
    output logic                   pend_reg_valid,
    output logic [REG_ADDR_W-1:0]  pend_reg_addr,
    output logic                   pend_vreg_valid,
    output logic [VREG_ADDR_W-1:0] pend_vreg_addr
`ifdef WB_ARB_STATS_EN
    ,
    output logic [STAT_CNT_W-1:0]  conflict_cnt,
    output logic [STAT_CNT_W-1:0]  stall_cnt
`endif
);

    logic reg_stall_s;
    logic vec_stall_s;

    wb_arb_lane #(.ADDR_W(REG_ADDR_W)) u_reg_lane (
        .clk        (clk),
        .rst        (rst),
        .s_req      (scalar_rreq),
        .v_req      (vector_rreq),
        .s_addr     (scalar_raddr),
        .v_addr     (vector_raddr),
        .sel        (register_wb_sel),
        .bsel       (buffer_register_sel),
        .load       (buffer_register),
        .waddr      (register_waddr),
        .stall_req  (reg_stall_s),
        .pend_valid (pend_reg_valid),
        .pend_addr  (pend_reg_addr)
    );

    wb_arb_lane #(.ADDR_W(VREG_ADDR_W)) u_vec_lane (
        .clk        (clk),
        .rst        (rst),
        .s_req      (scalar_vreq),
        .v_req      (vector_vreq),
        .s_addr     (scalar_vaddr),
        .v_addr     (vector_vaddr),
        .sel        (vector_wb_sel),
        .bsel       (buffer_vector_sel),
        .load       (buffer_vector),
        .waddr      (vector_waddr),
        .stall_req  (vec_stall_s),
        .pend_valid (pend_vreg_valid),
        .pend_addr  (pend_vreg_addr)
    );

    // Killing the scalar write in both files keeps its replay ordered behind vector writes.
    assign stall_scalar   = reg_stall_s | vec_stall_s;
    assign scalar_wb_kill = stall_scalar;

`ifdef WB_ARB_STATS_EN
    logic                  reg_conflict_s;
    logic                  vec_conflict_s;
    logic [1:0]            conflict_inc_s;
    logic [STAT_CNT_W-1:0] conflict_cnt_r;
    logic [STAT_CNT_W-1:0] stall_cnt_r;

    // A lane goes EMPTY->FULL exactly when it is empty and both pipelines request it.
    assign reg_conflict_s = ~pend_reg_valid  & scalar_rreq & vector_rreq;
    assign vec_conflict_s = ~pend_vreg_valid & scalar_vreq & vector_vreq;
    assign conflict_inc_s = {1'b0, reg_conflict_s} + {1'b0, vec_conflict_s};

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflict_cnt_r <= {STAT_CNT_W{1'b0}};
            stall_cnt_r    <= {STAT_CNT_W{1'b0}};
        end else begin
            conflict_cnt_r <= sat_add(conflict_cnt_r, conflict_inc_s);
            stall_cnt_r    <= sat_add(stall_cnt_r, {1'b0, stall_scalar});
        end
    end

    assign conflict_cnt = conflict_cnt_r;
    assign stall_cnt    = stall_cnt_r;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts each
// cycle's outputs, a negedge monitor pops and compares them.
module tb_wb_arbiter;

    logic       clk;
    logic       rst;
    logic       scalar_rreq, scalar_vreq, vector_rreq, vector_vreq;
    logic [4:0] scalar_raddr, vector_raddr, scalar_vaddr, vector_vaddr;
    logic       register_wb_sel, buffer_register_sel, buffer_register;
    logic       vector_wb_sel, buffer_vector_sel, buffer_vector;
    logic [4:0] register_waddr, vector_waddr;
    logic       stall_scalar, scalar_wb_kill;
    logic       pend_reg_valid, pend_vreg_valid;
    logic [4:0] pend_reg_addr, pend_vreg_addr;
`ifdef WB_ARB_STATS_EN
    logic [15:0] conflict_cnt, stall_cnt;
`endif

    wb_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .scalar_rreq         (scalar_rreq),
        .scalar_vreq         (scalar_vreq),
        .vector_rreq         (vector_rreq),
        .vector_vreq         (vector_vreq),
        .scalar_raddr        (scalar_raddr),
        .vector_raddr        (vector_raddr),
        .scalar_vaddr        (scalar_vaddr),
        .vector_vaddr        (vector_vaddr),
        .register_wb_sel     (register_wb_sel),
        .buffer_register_sel (buffer_register_sel),
        .buffer_register     (buffer_register),
        .vector_wb_sel       (vector_wb_sel),
        .buffer_vector_sel   (buffer_vector_sel),
        .buffer_vector       (buffer_vector),
        .register_waddr      (register_waddr),
        .vector_waddr        (vector_waddr),
        .stall_scalar        (stall_scalar),
        .scalar_wb_kill      (scalar_wb_kill),
        .pend_reg_valid      (pend_reg_valid),
        .pend_reg_addr       (pend_reg_addr),
        .pend_vreg_valid     (pend_vreg_valid),
        .pend_vreg_addr      (pend_vreg_addr)
`ifdef WB_ARB_STATS_EN
        ,
        .conflict_cnt        (conflict_cnt),
        .stall_cnt           (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rsel, rbsel, rload;
        logic [4:0]  rwa;
        logic        vsel, vbsel, vload;
        logic [4:0]  vwa;
        logic        stall;
        logic        prv;
        logic [4:0]  pra;
        logic        pvv;
        logic [4:0]  pva;
        logic [15:0] ccnt, scnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] rbuf[$];
    logic [4:0] vbuf[$];
    logic [4:0] rlast, vlast;
    int         ccnt, scnt;
    logic       last_stall;
    int         tests, fails, cyc;
    exp_t       mon_e;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, want);
        end
    endtask

    // Who writes the file this cycle: a parked vector result drains first,
    // otherwise scalar wins and a colliding vector result is parked for one cycle.
    function automatic void lane_model(
        input  logic s, v, input logic [4:0] sa, va, input int n, input logic [4:0] head,
        output logic sel, bsel, load, output logic [4:0] wa, output logic st, output logic park);
        sel = 1'b0; bsel = 1'b0; load = 1'b0; st = 1'b0; park = 1'b0; wa = sa;
        if (n > 0) begin
            sel = 1'b1; bsel = 1'b1; wa = head; st = s; load = v; park = v;
        end else if (s && v) begin
            load = 1'b1; park = 1'b1;
        end else if (v) begin
            sel = 1'b1; wa = va;
        end
    endfunction

    task automatic drive(input logic r, input logic srr, svr, vrr, vvr,
                         input logic [4:0] sra, vra, sva, vva);
        exp_t e;
        logic rst_q, vst_q, rpark, vpark;
        int   conf;
        @(posedge clk);
        #1;
        rst = r;
        scalar_rreq = srr; scalar_vreq = svr; vector_rreq = vrr; vector_vreq = vvr;
        scalar_raddr = sra; vector_raddr = vra; scalar_vaddr = sva; vector_vaddr = vva;
        e = '0;
        e.ccnt = 16'(ccnt);
        e.scnt = 16'(scnt);
        if (!r) begin
            exp_q.push_back(e);
            rbuf.delete(); vbuf.delete();
            rlast = 5'd0; vlast = 5'd0; ccnt = 0; scnt = 0; last_stall = 1'b0;
        end else begin
            lane_model(srr, vrr, sra, vra, rbuf.size(), (rbuf.size() > 0) ? rbuf[0] : 5'd0,
                       e.rsel, e.rbsel, e.rload, e.rwa, rst_q, rpark);
            lane_model(svr, vvr, sva, vva, vbuf.size(), (vbuf.size() > 0) ? vbuf[0] : 5'd0,
                       e.vsel, e.vbsel, e.vload, e.vwa, vst_q, vpark);
            e.stall = rst_q | vst_q;
            e.prv = (rbuf.size() > 0); e.pra = rlast;
            e.pvv = (vbuf.size() > 0); e.pva = vlast;
            exp_q.push_back(e);
            conf = ((rbuf.size() == 0 && srr && vrr) ? 1 : 0) + ((vbuf.size() == 0 && svr && vvr) ? 1 : 0);
            if (rbuf.size() > 0) void'(rbuf.pop_front());
            if (vbuf.size() > 0) void'(vbuf.pop_front());
            if (rpark) begin rbuf.push_back(vra); rlast = vra; end
            if (vpark) begin vbuf.push_back(vva); vlast = vva; end
            ccnt = (ccnt + conf > 65535) ? 65535 : ccnt + conf;
            if (e.stall) scnt = (scnt + 1 > 65535) ? 65535 : scnt + 1;
            last_stall = e.stall;
        end
    endtask

    // Monitor: compare every presented output cycle against the next expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            cyc++;
            chk("register_wb_sel", 16'(register_wb_sel), 16'(mon_e.rsel));
            chk("buffer_register_sel", 16'(buffer_register_sel), 16'(mon_e.rbsel));
            chk("buffer_register", 16'(buffer_register), 16'(mon_e.rload));
            chk("register_waddr", 16'(register_waddr), 16'(mon_e.rwa));
            chk("vector_wb_sel", 16'(vector_wb_sel), 16'(mon_e.vsel));
            chk("buffer_vector_sel", 16'(buffer_vector_sel), 16'(mon_e.vbsel));
            chk("buffer_vector", 16'(buffer_vector), 16'(mon_e.vload));
            chk("vector_waddr", 16'(vector_waddr), 16'(mon_e.vwa));
            chk("stall_scalar", 16'(stall_scalar), 16'(mon_e.stall));
            chk("scalar_wb_kill", 16'(scalar_wb_kill), 16'(mon_e.stall));
            chk("pend_reg_valid", 16'(pend_reg_valid), 16'(mon_e.prv));
            chk("pend_reg_addr", 16'(pend_reg_addr), 16'(mon_e.pra));
            chk("pend_vreg_valid", 16'(pend_vreg_valid), 16'(mon_e.pvv));
            chk("pend_vreg_addr", 16'(pend_vreg_addr), 16'(mon_e.pva));
`ifdef WB_ARB_STATS_EN
            chk("conflict_cnt", conflict_cnt, mon_e.ccnt);
            chk("stall_cnt", stall_cnt, mon_e.scnt);
`endif
        end
    end

    logic       hsr, hsv;
    logic [4:0] hsra, hsva;

    initial begin
        tests = 0; fails = 0; cyc = 0;
        rlast = 5'd0; vlast = 5'd0; ccnt = 0; scnt = 0; last_stall = 1'b0;
        rst = 1'b0;
        scalar_rreq = 1'b1; scalar_vreq = 1'b1; vector_rreq = 1'b1; vector_vreq = 1'b1;
        scalar_raddr = 5'd1; vector_raddr = 5'd2; scalar_vaddr = 5'd3; vector_vaddr = 5'd4;

        // Reset held with every request asserted.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 5'd4);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3, 5'd4);
        // Register-file conflict, then drain.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd7, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        // Overflow: conflict, then a second conflict while 7 drains, scalar replays.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd7, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 5'd9, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 5'd0, 5'd0, 5'd0);
        // Lane independence: vector-file conflict with a vector-only register write.
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 5'd6, 5'd2, 5'd5);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        // Mid-operation reset discards parked vector-file address 12.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd1, 5'd12);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);

        // Random traffic; a stalled scalar request is re-presented unchanged.
        hsr = 1'b0; hsv = 1'b0; hsra = 5'd0; hsva = 5'd0;
        for (int i = 0; i < 1500; i++) begin
            if (!last_stall) begin
                hsr  = 1'($urandom_range(0, 1));
                hsv  = 1'($urandom_range(0, 1));
                hsra = 5'($urandom_range(0, 31));
                hsva = 5'($urandom_range(0, 31));
            end
            drive(($urandom_range(0, 99) != 0), hsr, hsv,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  hsra, 5'($urandom_range(0, 31)), hsva, 5'($urandom_range(0, 31)));
        end

`ifdef WB_ARB_STATS_EN
        // Continuous register-file contention stalls every cycle until stall_cnt saturates.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 65545; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, 5'd0);
        end
`endif

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
